aes_inv_key_sched: RTL and testbench
====================================

AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
REQ-001 SHALL have no parameters; the block is fixed to AES-128 (10 rounds, 128-bit round keys).
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst_n`, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port `key_valid`, input, 1 bit: cipher key offered on `key_in`.
REQ-005 SHALL have port `key_ready`, output, 1 bit: block can accept a cipher key.
REQ-006 SHALL have port `key_in`, input, 128 bits: cipher key; word w0 = [127:96], w3 = [31:0].
REQ-007 SHALL have port `rk_valid`, output, 1 bit: round key presented on `rk_out`.
REQ-008 SHALL have port `rk_ready`, input, 1 bit: consumer accepts the round key.
REQ-009 SHALL have port `rk_out`, output, 128 bits: round key, same word order as `key_in`.
REQ-010 SHALL have port `rk_index`, output, 4 bits: round number of `rk_out`, 10 down to 0.
REQ-011 SHALL have port `rk_last`, output, 1 bit: high when `rk_index` == 0 and `rk_valid` is high.
REQ-012 SHALL have port `busy`, output, 1 bit: high in the EXPAND and EMIT states.

Function
REQ-013 SHALL implement three states: IDLE, EXPAND and EMIT.
REQ-014 SHALL hold `key_ready` high only in IDLE; a key is accepted on a rising edge where `key_valid` && `key_ready`.
REQ-015 On key acceptance, SHALL load `key_in` into the key register, set the round counter to 1 and enter EXPAND.
REQ-016 In EXPAND, SHALL perform one forward FIPS-197 step per cycle: w4 = w0 ^ SubWord(RotWord(w3)) ^ Rcon[i], w5 = w4 ^ w1, w6 = w5 ^ w2, w7 = w6 ^ w3.
REQ-017 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36, placed in the top byte of the word.
REQ-018 After exactly 10 EXPAND cycles, the register SHALL hold round key 10, `rk_index` SHALL be 10, and the block SHALL enter EMIT.
REQ-019 The first `rk_valid` SHALL occur 11 cycles after the acceptance edge.
REQ-020 In EMIT, SHALL hold `rk_valid` high and drive `rk_out` from the register.
REQ-021 On each `rk_valid` && `rk_ready` edge with index i > 0, SHALL replace the register with round key i-1, computed by inverse step:
- w3' = w7 ^ w6; w2' = w6 ^ w5; w1' = w5 ^ w4;
- w0' = w4 ^ SubWord(RotWord(w3')) ^ Rcon[i];
- decrement `rk_index`.
REQ-022 Inverse throughput SHALL be one round key per cycle while `rk_ready` is held high.
REQ-023 On a `rk_valid` && `rk_ready` edge with index 0, SHALL return to IDLE, deassert `rk_valid` and clear `rk_index`.
REQ-024 While `rk_valid` && !`rk_ready`, SHALL hold `rk_out`, `rk_index` and `rk_last` stable.
REQ-025 `key_valid` outside IDLE SHALL be ignored with no effect on state.
REQ-026 SHALL use one set of four S-box lookups, shared between EXPAND and EMIT via an input mux.
REQ-027 `rk_out` SHALL be 0 whenever `rk_valid` is low.

Reset
REQ-028 On a rising edge with `rst_n` low, SHALL enter IDLE and set the key register, round counter and `rk_index` to 0.
REQ-029 During reset, SHALL hold `rk_valid`, `rk_last` and `busy` at 0 and `key_ready` at 1 from the first edge after release.
REQ-030 Reset asserted mid-EXPAND or mid-EMIT SHALL abort the operation; no partial keys are emitted after release.

Verification
REQ-031 Load FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c with `rk_ready`=1 -> rk 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at acceptance+11, rk 9 = ac7766f319fadc2128d12941575c006e, rk 1 = a0fafe1788542cb123a339392a6c7605, rk 0 = original key with `rk_last`=1; then IDLE.
REQ-032 Same key, `rk_ready` low for 5 cycles while at index 7 -> `rk_out`/`rk_index` stable for all 5 cycles, then the sequence continues correctly.
REQ-033 `key_valid` pulsed with key 000102030405060708090a0b0c0d0e0f during EXPAND and EMIT -> ignored; the emitted sequence is for the first key only.
REQ-034 `rst_n` low for 1 cycle at EXPAND cycle 5, then reload the A.1 key -> no `rk_valid` before the new acceptance+11, and keys match REQ-031.
REQ-035 Two back-to-back keys (all-zero key, then the A.1 key) with random `rk_ready` -> all-zero key rk 10 = b4ef5bcb3e92e21123e951cf6f8f188e, and each key's 11 round keys match a reference model in order 10..0.

Source files
------------

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: expands the cipher key forward to round key 10 in 10 cycles,
// then emits round keys 10..0, one per rk_ready cycle; rk_out/rk_index hold while rk_ready is low.
module aes_inv_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_index,
  output logic         rk_last,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

  state_t       state, state_nxt;
  logic [127:0] key_q;
  logic [3:0]   rnd;

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] lsb;
    lsb = {~x, 3'b000};
    return SBOX_TBL[lsb +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  inv1, inv2, inv3;
  logic [31:0]  sub_src, rot, sub, tmix;
  logic [31:0]  fwd0, fwd1, fwd2, fwd3;
  logic [3:0]   rc_idx;
  logic [127:0] key_fwd, key_inv;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign inv3 = w3 ^ w2;
  assign inv2 = w2 ^ w1;
  assign inv1 = w1 ^ w0;

  // The single SubWord unit sees w3 while expanding and the recovered w3' while emitting.
  assign sub_src = (state == EMIT) ? inv3 : w3;
  assign rc_idx  = (state == EMIT) ? rk_index : rnd;
  assign rot     = {sub_src[23:0], sub_src[31:24]};
  assign sub     = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign tmix    = sub ^ {rcon(rc_idx), 24'h000000};

  assign fwd0 = w0 ^ tmix;
  assign fwd1 = fwd0 ^ w1;
  assign fwd2 = fwd1 ^ w2;
  assign fwd3 = fwd2 ^ w3;

  assign key_fwd = {fwd0, fwd1, fwd2, fwd3};
  assign key_inv = {w0 ^ tmix, inv1, inv2, inv3};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      key_q    <= '0;
      rnd      <= '0;
      rk_index <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (key_valid) begin
            key_q <= key_in;
            rnd   <= 4'd1;
          end
        end
        EXPAND: begin
          key_q <= key_fwd;
          if (rnd == 4'd10) begin
            rnd      <= '0;
            rk_index <= 4'd10;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        EMIT: begin
          if (rk_ready && (rk_index != 4'd0)) begin
            key_q    <= key_inv;
            rk_index <= rk_index - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    rk_valid  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_nxt = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (rnd == 4'd10) state_nxt = EMIT;
      end
      EMIT: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
        if (rk_ready && (rk_index == 4'd0)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rk_out  = rk_valid ? key_q : '0;
  assign rk_last = rk_valid && (rk_index == 4'd0);

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: GF(2^8)-derived S-box and word-array key expansion as reference,
// FIPS-197 constant table, stall / ignored-key / reset-abort sequences and random keys and backpressure.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst_n, key_valid, key_ready, rk_valid, rk_ready, rk_last, busy;
  logic [127:0] key_in, rk_out;
  logic [3:0]   rk_index;

  always #5 clk = ~clk;

  aes_inv_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_out    (rk_out),
    .rk_index  (rk_index),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ALT = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    logic         sel_zero;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  int           total = 0;
  int           bad   = 0;
  logic [7:0]   sb [256];
  logic [127:0] mdl [11];
  logic [127:0] got [11];
  logic [127:0] got_a1 [11];
  logic [127:0] got_zero [11];
  vec_t         tbl [6];

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  task automatic compute_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_idle(string tag);
    chk({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
    chk({tag, "_key_ready"}, 128'(key_ready), 128'(1));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_rk_index"}, 128'(rk_index), 128'(0));
    chk({tag, "_rk_last"}, 128'(rk_last), 128'(0));
    chk({tag, "_rk_out"}, rk_out, 128'(0));
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 5 cycles at index 7, 3: stray keys while busy.
  // Entered and left at a negedge with the DUT idle.
  task automatic run_seq(input logic [127:0] k, input int mode);
    int           n, hs, stall, first;
    logic         prev_stall;
    logic [127:0] prev_out;
    logic [3:0]   prev_idx;
    compute_model(k);
    chk("pre_key_ready", 128'(key_ready), 128'(1));
    key_in    = k;
    key_valid = 1'b1;
    rk_ready  = 1'b1;
    @(posedge clk); #1;
    key_valid  = 1'b0;
    n = 0; hs = 0; stall = 0; first = 0;
    prev_stall = 1'b0;
    prev_out   = '0;
    prev_idx   = '0;
    while (hs < 11 && n < 300) begin
      case (mode)
        1: rk_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (hs == 3 && stall < 5) begin
            rk_ready = 1'b0;
            stall++;
          end else rk_ready = 1'b1;
        end
        default: rk_ready = 1'b1;
      endcase
      key_valid = (mode == 3) && (n == 2 || n == 12);
      key_in    = key_valid ? KEY_ALT : k;
      n++;
      @(negedge clk);
      chk("busy_during_run", 128'(busy), 128'(1));
      chk("key_ready_during_run", 128'(key_ready), 128'(0));
      if (rk_valid) begin
        if (first == 0) begin
          first = n;
          chk("first_valid_cycle", 128'(n), 128'(11));
        end
        chk("rk_index", 128'(rk_index), 128'(10 - hs));
        chk("rk_last", 128'(rk_last), 128'(hs == 10));
        chk("rk_out", rk_out, mdl[10-hs]);
        if (!rk_ready && prev_stall) begin
          chk("stall_out_stable", rk_out, prev_out);
          chk("stall_idx_stable", 128'(rk_index), 128'(prev_idx));
        end
        prev_stall = !rk_ready;
        prev_out   = rk_out;
        prev_idx   = rk_index;
        if (rk_ready) begin
          got[10-hs] = rk_out;
          hs++;
        end
      end else begin
        chk("rk_out_zero_when_invalid", rk_out, 128'(0));
      end
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    if (hs < 11) chk("timeout_round_keys", 128'(hs), 128'(11));
    if (mode == 2) chk("stall_cycles", 128'(stall), 128'(5));
    @(negedge clk);
    check_idle("after_seq");
  endtask

  // Accept A.1, let it run `cycles` edges with rk_ready low, pulse reset for one edge, then watch.
  task automatic reset_abort(input int cycles, string tag);
    int seen;
    key_in    = KEY_A1;
    key_valid = 1'b1;
    rk_ready  = 1'b0;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    check_idle(tag);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (rk_valid) seen++;
    end
    chk({tag, "_no_valid_after_abort"}, 128'(seen), 128'(0));
  endtask

  initial begin
    tbl[0] = '{1'b0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[1] = '{1'b0,  9, 128'hac7766f319fadc2128d12941575c006e};
    tbl[2] = '{1'b0,  1, 128'ha0fafe1788542cb123a339392a6c7605};
    tbl[3] = '{1'b0,  0, KEY_A1};
    tbl[4] = '{1'b1, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    tbl[5] = '{1'b1,  0, 128'h0};

    build_sbox();
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rk_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset");

    run_seq(KEY_A1, 0);
    got_a1 = got;
    run_seq(KEY_A1, 2);
    run_seq(KEY_A1, 3);

    reset_abort(4, "abort_expand");
    run_seq(KEY_A1, 0);
    reset_abort(13, "abort_emit");

    run_seq(128'h0, 1);
    got_zero = got;
    run_seq(KEY_A1, 1);

    for (int r = 0; r < 3; r++)
      run_seq({$urandom, $urandom, $urandom, $urandom}, 1);

    for (int i = 0; i < 6; i++)
      chk($sformatf("fips_vec%0d_rk%0d", i, tbl[i].idx),
          tbl[i].sel_zero ? got_zero[tbl[i].idx] : got_a1[tbl[i].idx], tbl[i].exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
